// File: rtl/lia_pkg.sv
// Shared constants, FSM state type and the packed-bus slice helper for the
// lock-in readout arbiter.
package lia_pkg;

  localparam int N_CH = 8;
  localparam int DW   = 16;
  localparam int CW   = 3;
  localparam int SW   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  // Channel idx occupies bits [idx*DW +: DW] of a packed per-channel bus.
  function automatic logic [DW-1:0] ch_slice(input logic [N_CH*DW-1:0] bus,
                                             input int idx);
    return bus[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/lia_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from the top channel back to channel 0.
module lia_rr_arb
  import lia_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [CW-1:0]   idx,
  output logic            any_req
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_CH; k++) begin
      j = (int'(ptr) + k) % N_CH;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = CW'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/lia_readout_arbiter.sv
// Captures per-channel lock-in X/Y strobes into holding registers and hands
// them one at a time, round-robin, to a valid/ready port. Optional build
// macro LIA_RDOUT_SEQ_EN adds a per-channel capture sequence number (out_seq).
module lia_readout_arbiter
  import lia_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH*DW-1:0]   ch_x,
  input  logic [N_CH*DW-1:0]   ch_y,
  input  logic [N_CH-1:0]      ch_valid,
  input  logic [N_CH-1:0]      ch_en,
  output logic [DW-1:0]        out_x,
  output logic [DW-1:0]        out_y,
  output logic [CW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_CH-1:0]      overrun,
  input  logic                 overrun_clr,
`ifdef LIA_RDOUT_SEQ_EN
  output logic [SW-1:0]        out_seq,
`endif
  output logic [1:0]           fsm_state
);

  // Output handshake: a result transfers on any rising edge where out_valid
  // and out_ready are both high; out_x/out_y/out_ch (and out_seq) hold steady
  // while out_valid is high, and out_ready with out_valid low has no effect.

  state_t          state, state_nxt;
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] ld_mask;
  logic [CW-1:0]   grant_idx;
  logic [CW-1:0]   rr_ptr;
  logic            any_req;
  logic            load;
  logic [DW-1:0]   hold_x [N_CH];
  logic [DW-1:0]   hold_y [N_CH];

  assign cap       = ch_valid & ch_en;
  assign req       = pend & ch_en;
  assign load      = (state == LOAD) && any_req;
  assign ld_mask   = load ? grant : '0;
  assign out_valid = (state == PRESENT);
  assign fsm_state = state;

  lia_rr_arb u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (grant_idx),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Incoming strobes count as work so a lone result reaches the port in two
  // cycles; a LOAD that finds nothing (channel disabled meanwhile) falls back.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req || |cap) state_nxt = LOAD;
      LOAD:    state_nxt = any_req ? PRESENT : IDLE;
      PRESENT: if (out_ready) state_nxt = (|req || |cap) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      overrun <= '0;
      rr_ptr  <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_ch  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hold_x[i] <= '0;
        hold_y[i] <= '0;
      end
    end else begin
      // A strobe on the channel being loaded re-arms it rather than overrunning.
      pend    <= cap | (pend & ch_en & ~ld_mask);
      overrun <= (overrun_clr ? '0 : overrun) | (cap & pend & ~ld_mask);
      for (int i = 0; i < N_CH; i++) begin
        if (cap[i]) begin
          hold_x[i] <= ch_slice(ch_x, i);
          hold_y[i] <= ch_slice(ch_y, i);
        end
      end
      if (load) begin
        out_x  <= hold_x[grant_idx];
        out_y  <= hold_y[grant_idx];
        out_ch <= grant_idx;
        rr_ptr <= CW'((int'(grant_idx) + 1) % N_CH);
      end
    end
  end

`ifdef LIA_RDOUT_SEQ_EN
  logic [SW-1:0] seq_cnt  [N_CH];
  logic [SW-1:0] hold_seq [N_CH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_seq <= '0;
      for (int i = 0; i < N_CH; i++) begin
        seq_cnt[i]  <= '0;
        hold_seq[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (cap[i]) begin
          hold_seq[i] <= seq_cnt[i];
          seq_cnt[i]  <= seq_cnt[i] + 8'd1;
        end
      end
      if (load) out_seq <= hold_seq[grant_idx];
    end
  end
`endif

endmodule

// File: tb/tb_lia_readout_arbiter.sv
// Directed bench for lia_readout_arbiter: a per-cycle vector table for the
// single-result, overrun and collision cases, plus hand-written sequences.
module tb_lia_readout_arbiter;
  import lia_pkg::*;

  localparam int EW = CW + 2 * DW;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N_CH*DW-1:0]  ch_x;
  logic [N_CH*DW-1:0]  ch_y;
  logic [N_CH-1:0]     ch_valid;
  logic [N_CH-1:0]     ch_en;
  logic [DW-1:0]       out_x;
  logic [DW-1:0]       out_y;
  logic [CW-1:0]       out_ch;
  logic                out_valid;
  logic                out_ready;
  logic [N_CH-1:0]     overrun;
  logic                overrun_clr;
  logic [1:0]          fsm_state;
`ifdef LIA_RDOUT_SEQ_EN
  logic [SW-1:0]       out_seq;
  logic [SW-1:0]       seq_q[$];
`endif

  lia_readout_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ch_x        (ch_x),
    .ch_y        (ch_y),
    .ch_valid    (ch_valid),
    .ch_en       (ch_en),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
`ifdef LIA_RDOUT_SEQ_EN
    .out_seq     (out_seq),
`endif
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [N_CH-1:0] valid;
    logic [CW-1:0]   ch;
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic            ready;
    logic            clr;
    logic            e_valid;
    logic [CW-1:0]   e_ch;
    logic [DW-1:0]   e_x;
    logic [DW-1:0]   e_y;
    logic [N_CH-1:0] e_ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] valid, input logic [2:0] ch, input logic [15:0] x,
                     input logic [15:0] y, input logic ready, input logic clr,
                     input logic e_valid, input logic [2:0] e_ch, input logic [15:0] e_x,
                     input logic [15:0] e_y, input logic [7:0] e_ovr);
    vec_t v;
    v.valid = valid; v.ch = ch; v.x = x; v.y = y; v.ready = ready; v.clr = clr;
    v.e_valid = e_valid; v.e_ch = e_ch; v.e_x = e_x; v.e_y = e_y; v.e_ovr = e_ovr;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe every channel in mask once; channel i carries X = base + i, Y = ~X.
  task automatic strobe(input logic [N_CH-1:0] mask, input logic [DW-1:0] base);
    for (int i = 0; i < N_CH; i++) begin
      ch_x[i*DW +: DW] = base + DW'(i);
      ch_y[i*DW +: DW] = ~(base + DW'(i));
    end
    ch_valid = mask;
    step();
    ch_valid = '0;
  endtask

  task automatic push_exp(input int c, input logic [DW-1:0] base);
    logic [DW-1:0] x;
    x = base + DW'(c);
    exp_q.push_back({CW'(c), x, ~x});
  endtask

  // Accept n results with out_ready held high, comparing each against exp_q.
  task automatic drain(input int n, input bit chk_gap);
    int got;
    int cyc;
    int last;
    logic [EW-1:0] e;
    got = 0; cyc = 0; last = -1;
    out_ready = 1'b1;
    while (got < n && cyc < 64) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("hs_ch", 64'(out_ch), 64'(e[EW-1 -: CW]));
        chk("hs_x", 64'(out_x), 64'(e[2*DW-1 -: DW]));
        chk("hs_y", 64'(out_y), 64'(e[DW-1:0]));
`ifdef LIA_RDOUT_SEQ_EN
        if (seq_q.size() > 0) chk("out_seq", 64'(out_seq), 64'(seq_q.pop_front()));
`endif
        if (chk_gap && last >= 0) chk("hs_gap", 64'(cyc - last), 64'd2);
        last = cyc;
        got++;
      end
      step();
      cyc++;
    end
    if (got < n) chk("drain_timeout", 64'(got), 64'(n));
  endtask

  task automatic count_valid(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (out_valid) hits++;
    end
  endtask

  initial begin
    int hits;
    reset_n = 1'b0; ch_x = '0; ch_y = '0; ch_valid = '0; ch_en = 8'hFF;
    out_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_x", 64'(out_x), 64'd0);
    chk("rst_y", 64'(out_y), 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_state", 64'(fsm_state), 64'd0);
    reset_n = 1'b1;

    // single result on ch3, two-cycle latency, one-cycle handshake
    add(8'h08, 3, 16'h1234, 16'hABCD, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  1, 3, 16'h1234, 16'hABCD, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    // backpressure: ch5 holds the port while ch2 is strobed twice
    add(8'h20, 5, 16'h0055, 16'h5555, 0, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h04, 2, 16'h0001, 16'h0101, 0, 0,  1, 5, 16'h0055, 16'h5555, 8'h00);
    add(8'h04, 2, 16'h0002, 16'h0202, 0, 0,  1, 5, 16'h0055, 16'h5555, 8'h04);
    add(8'h00, 0, 16'h0000, 16'h0000, 0, 0,  1, 5, 16'h0055, 16'h5555, 8'h04);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h04);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  1, 2, 16'h0002, 16'h0202, 8'h04);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 1,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    // overrun_clr coincident with a new overrun: set wins
    add(8'h01, 0, 16'h000A, 16'hA000, 0, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 0, 0,  1, 0, 16'h000A, 16'hA000, 8'h00);
    add(8'h01, 0, 16'h000B, 16'hB000, 0, 0,  1, 0, 16'h000A, 16'hA000, 8'h00);
    add(8'h01, 0, 16'h000C, 16'hC000, 0, 1,  1, 0, 16'h000A, 16'hA000, 8'h01);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h01);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  1, 0, 16'h000C, 16'hC000, 8'h01);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 1,  0, 0, 16'h0000, 16'h0000, 8'h00);
    // strobe on the channel being loaded: old data out, new data kept pending
    add(8'h02, 1, 16'h0011, 16'h1100, 0, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h02, 1, 16'h0022, 16'h2200, 0, 0,  1, 1, 16'h0011, 16'h1100, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  1, 1, 16'h0022, 16'h2200, 8'h00);
    add(8'h00, 0, 16'h0000, 16'h0000, 1, 0,  0, 0, 16'h0000, 16'h0000, 8'h00);

    for (int r = 0; r < tbl.size(); r++) begin
      ch_x = '0;
      ch_y = '0;
      ch_x[int'(tbl[r].ch)*DW +: DW] = tbl[r].x;
      ch_y[int'(tbl[r].ch)*DW +: DW] = tbl[r].y;
      ch_valid    = tbl[r].valid;
      out_ready   = tbl[r].ready;
      overrun_clr = tbl[r].clr;
      step();
      chk($sformatf("tbl%0d_valid", r), 64'(out_valid), 64'(tbl[r].e_valid));
      if (tbl[r].e_valid) begin
        chk($sformatf("tbl%0d_ch", r), 64'(out_ch), 64'(tbl[r].e_ch));
        chk($sformatf("tbl%0d_x", r), 64'(out_x), 64'(tbl[r].e_x));
        chk($sformatf("tbl%0d_y", r), 64'(out_y), 64'(tbl[r].e_y));
      end
      chk($sformatf("tbl%0d_ovr", r), 64'(overrun), 64'(tbl[r].e_ovr));
    end
    ch_valid = '0; overrun_clr = 1'b0;
    chk("tbl_end_idle", 64'(fsm_state), 64'd0);

    // fairness: ch7 alone moves the pointer to 0, then all eight at once
    strobe(8'h80, 16'h0700); push_exp(7, 16'h0700); drain(1, 0);
    strobe(8'hFF, 16'h0000);
    for (int k = 0; k < N_CH; k++) push_exp(k, 16'h0000);
    drain(8, 1);
    // ch4 alone leaves the pointer at 5
    strobe(8'h10, 16'h0040); push_exp(4, 16'h0040); drain(1, 0);
    strobe(8'hFF, 16'h0100);
    for (int k = 0; k < N_CH; k++) push_exp((5 + k) % N_CH, 16'h0100);
    drain(8, 1);

    // disable drop: ch6 disabled the cycle after its strobe
    out_ready = 1'b1;
    strobe(8'h40, 16'h0600);
    ch_en = 8'hBF;
    count_valid(6, hits);
    chk("dis_no_out", 64'(hits), 64'd0);
    chk("dis_ovr", 64'(overrun), 64'd0);
    ch_en = 8'hFF;
    strobe(8'h02, 16'h0900); push_exp(1, 16'h0900); drain(1, 0);
    count_valid(6, hits);
    chk("dis_no_stale", 64'(hits), 64'd0);

    // reset while presenting, with a pending overrun behind it
    out_ready = 1'b0;
    strobe(8'h04, 16'h0200);
    step();
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    strobe(8'h20, 16'h0500);
    strobe(8'h20, 16'h0600);
    chk("rst_pre_ovr", 64'(overrun), 64'h20);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_x", 64'(out_x), 64'd0);
    chk("rst_mid_y", 64'(out_y), 64'd0);
    chk("rst_mid_ch", 64'(out_ch), 64'd0);
    chk("rst_mid_ovr", 64'(overrun), 64'd0);
    chk("rst_mid_state", 64'(fsm_state), 64'd0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    count_valid(8, hits);
    chk("rst_no_stale", 64'(hits), 64'd0);

`ifdef LIA_RDOUT_SEQ_EN
    for (int k = 0; k < 257; k++) begin
      strobe(8'h02, DW'(k));
      push_exp(1, DW'(k));
      seq_q.push_back(SW'(k));
      drain(1, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
